// File: rtl/uart_8n1_pkg.sv
// Shared definitions for the uart_8n1 host-side bridge: byte width, tx FSM states, error counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_8n1_pkg;

  localparam int BYTE_W    = 8;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_WRITE = 2'd1,
    TX_HOLD  = 2'd2
  } tx_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_8n1_fifo_bridge_if.sv
// Host-side byte streams of the bridge: a push stream into tx and a show-ahead pop stream out of rx.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates pushes, out_ready gates pops.
interface uart_8n1_fifo_bridge_if;
  import uart_8n1_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/uart_8n1_byte_fifo.sv
// Register-array byte FIFO with show-ahead head and an occupancy counter.
// Latency: head/level reflect a push or pop on the cycle after it.
// Backpressure: push while full is taken only together with a pop; the parent owns the policy.
module uart_8n1_byte_fifo
  import uart_8n1_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  // full/empty come from the level counter, so pointers can simply wrap.
  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves level unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_8n1_fifo_bridge.sv
// Buffers host bytes into uart_8n1's tx holding register and captures its received bytes for the host.
// Latency: tx byte reaches uart_tx_write 2 cycles after push at best; rx byte visible 1 cycle after uart_rx_full.
// Backpressure: in_ready drops when tx FIFO is full; rx bytes arriving to a full FIFO are dropped and flagged.
module uart_8n1_fifo_bridge
  import uart_8n1_pkg::*;
#(
  parameter int FIFO_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_8n1_fifo_bridge_if.slave host,
  output logic [FIFO_ADDR_W:0]  tx_level,
  output logic [FIFO_ADDR_W:0]  rx_level,
  output logic                  rx_overrun,
  output logic [ERR_CNT_W-1:0]  rx_error_count,
  input  logic                  clear_status,
  output logic [BYTE_W-1:0]     uart_tx_data,
  output logic                  uart_tx_write,
  input  logic                  uart_tx_full,
  input  logic [BYTE_W-1:0]     uart_rx_data,
  input  logic                  uart_rx_full,
  input  logic                  uart_rx_error,
  output logic                  uart_rx_read
);

  tx_state_t         tx_state;
  tx_state_t         tx_next;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [BYTE_W-1:0] tx_head;
  logic              rx_pop;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_drop;
  logic              rx_error_prev;
  logic              rx_error_rise;

  // in_ready looks only at the registered level, so a pop in the same cycle cannot open a slot.
  assign host.in_ready = !tx_full;

  uart_8n1_byte_fifo #(.ADDR_W(FIFO_ADDR_W)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (host.in_valid && host.in_ready),
    .push_data (host.in_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .level     (tx_level),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // tx issue FSM: WRITE is a dead cycle that covers uart_tx_full's one-cycle lag.
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty && !uart_tx_full) begin
          tx_pop  = 1'b1;
          tx_next = TX_WRITE;
        end
      end
      TX_WRITE: tx_next = TX_HOLD;
      TX_HOLD:  if (!uart_tx_full) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // tx state register and registered strobe/data towards the UART.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state      <= TX_IDLE;
      uart_tx_write <= 1'b0;
      uart_tx_data  <= '0;
    end else begin
      tx_state      <= tx_next;
      uart_tx_write <= tx_pop;
      if (tx_pop) uart_tx_data <= tx_head;
    end
  end

  assign rx_pop         = host.out_valid && host.out_ready;
  assign host.out_valid = !rx_empty;
  // A full FIFO still accepts the byte when the host frees a slot in the same cycle.
  assign rx_drop        = uart_rx_full && rx_full && !rx_pop;
  assign rx_error_rise  = uart_rx_error && !rx_error_prev;

  uart_8n1_byte_fifo #(.ADDR_W(FIFO_ADDR_W)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (uart_rx_full),
    .push_data (uart_rx_data),
    .pop       (rx_pop),
    .head      (host.out_data),
    .level     (rx_level),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Receiver acknowledge and status; a new event beats a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_rx_read   <= 1'b0;
      rx_overrun     <= 1'b0;
      rx_error_count <= '0;
      rx_error_prev  <= 1'b0;
    end else begin
      uart_rx_read  <= uart_rx_full;
      rx_error_prev <= uart_rx_error;
      if (rx_drop)           rx_overrun <= 1'b1;
      else if (clear_status) rx_overrun <= 1'b0;
      if (rx_error_rise)     rx_error_count <= clear_status ? ERR_CNT_W'(1) : sat_inc(rx_error_count);
      else if (clear_status) rx_error_count <= '0;
    end
  end

endmodule

// File: tb/tb_uart_8n1_fifo_bridge.sv
// Self-checking bench for uart_8n1_fifo_bridge: queue-based model compared every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: uart_tx_full is driven directly by the stimulus.
module tb_uart_8n1_fifo_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear_status = 1'b0;
  logic       uart_tx_full = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_rx_full = 1'b0;
  logic       uart_rx_error = 1'b0;
  logic [4:0] tx_level;
  logic [4:0] rx_level;
  logic       rx_overrun;
  logic [7:0] rx_error_count;
  logic [7:0] uart_tx_data;
  logic       uart_tx_write;
  logic       uart_rx_read;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  uart_8n1_fifo_bridge_if host_if ();

  uart_8n1_fifo_bridge #(.FIFO_ADDR_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .host           (host_if.slave),
    .tx_level       (tx_level),
    .rx_level       (rx_level),
    .rx_overrun     (rx_overrun),
    .rx_error_count (rx_error_count),
    .clear_status   (clear_status),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_write  (uart_tx_write),
    .uart_tx_full   (uart_tx_full),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_full   (uart_rx_full),
    .uart_rx_error  (uart_rx_error),
    .uart_rx_read   (uart_rx_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: two byte queues, a tx "released" flag, status counters.
  byte unsigned m_txq[$];
  byte unsigned m_rxq[$];
  bit           m_ov = 0;
  int           m_cnt = 0;
  bit           m_prev = 0;
  bit           m_wr = 0;
  byte unsigned m_wd = 0;
  bit           m_rd = 0;
  bit           m_rel = 1;
  int           m_cyc = 0;
  int           m_last = -100;

  always @(posedge clk) begin
    int txn, rxn;
    bit iss, pop, ovev, rise;
    m_cyc++;
    if (reset) begin
      m_txq.delete(); m_rxq.delete();
      m_ov = 0; m_cnt = 0; m_prev = 0; m_wr = 0; m_wd = 0; m_rd = 0;
      m_rel = 1; m_last = -100;
    end else begin
      txn = m_txq.size();
      rxn = m_rxq.size();
      // A byte may go out once the UART has shown not-full at least two cycles after the last issue.
      iss = m_rel && txn > 0 && !uart_tx_full;
      if (!iss && (m_cyc - m_last) >= 2 && !uart_tx_full) m_rel = 1;
      if (iss) begin
        m_rel = 0;
        m_last = m_cyc;
        m_wd = m_txq.pop_front();
      end
      m_wr = iss;
      if (host_if.in_valid && txn < 16) m_txq.push_back(host_if.in_data);
      pop = rxn > 0 && host_if.out_ready;
      if (pop) m_rxq.delete(0);
      if (uart_rx_full && (rxn < 16 || pop)) m_rxq.push_back(uart_rx_data);
      ovev = uart_rx_full && rxn == 16 && !pop;
      if (ovev) m_ov = 1;
      else if (clear_status) m_ov = 0;
      rise = uart_rx_error && !m_prev;
      if (rise) m_cnt = clear_status ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
      else if (clear_status) m_cnt = 0;
      m_prev = uart_rx_error;
      m_rd = uart_rx_full;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", host_if.in_ready, m_txq.size() < 16);
      chk("tx_level", tx_level, m_txq.size());
      chk("rx_level", rx_level, m_rxq.size());
      chk("out_valid", host_if.out_valid, m_rxq.size() > 0);
      if (m_rxq.size() > 0) chk("out_data", host_if.out_data, m_rxq[0]);
      chk("rx_overrun", rx_overrun, m_ov);
      chk("rx_error_count", rx_error_count, m_cnt);
      chk("uart_tx_write", uart_tx_write, m_wr);
      chk("uart_tx_data", uart_tx_data, m_wd);
      chk("uart_rx_read", uart_rx_read, m_rd);
    end
  end

  // Log of bytes handed to the UART, with the negedge index they appeared on.
  byte unsigned wlog[$];
  int           wcyc[$];
  int           ncyc = 0;
  always @(negedge clk) begin
    ncyc++;
    if (uart_tx_write === 1'b1) begin
      wlog.push_back(uart_tx_data);
      wcyc.push_back(ncyc);
    end
  end

  initial begin
    host_if.in_data   = 8'h00;
    host_if.in_valid  = 1'b0;
    host_if.out_ready = 1'b0;
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_in_ready", host_if.in_ready, 1);
    chk("rst_out_valid", host_if.out_valid, 0);
    chk("rst_tx_write", uart_tx_write, 0);
    reset = 1'b0;

    // Two bytes with the UART always ready: back-to-back issue at the 3-cycle floor.
    host_if.in_valid = 1'b1; host_if.in_data = 8'hA5; step();
    host_if.in_data = 8'h3C; step();
    host_if.in_valid = 1'b0;
    repeat (10) step();
    chk("t1_count", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("t1_byte0", wlog[0], 8'hA5);
      chk("t1_byte1", wlog[1], 8'h3C);
      chk("t1_gap", wcyc[1] - wcyc[0], 3);
    end
    chk("t1_tx_level", tx_level, 0);

    // Fill tx FIFO while UART is busy; the 17th push must be refused.
    uart_tx_full = 1'b1;
    host_if.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      host_if.in_data = 8'h10 + 8'(i);
      step();
    end
    host_if.in_valid = 1'b0;
    chk("t2_tx_level", tx_level, 16);
    chk("t2_in_ready", host_if.in_ready, 0);
    uart_tx_full = 1'b0;
    repeat (60) step();
    chk("t2_count", wlog.size(), 18);
    for (int i = 0; i < 16; i++) begin
      if (wlog.size() > 2 + i) chk("t2_order", wlog[2 + i], 8'h10 + 8'(i));
    end
    chk("t2_tx_level", tx_level, 0);

    // Single received byte, acknowledge, then pop.
    uart_rx_full = 1'b1; uart_rx_data = 8'h55; step();
    uart_rx_full = 1'b0;
    chk("t3_out_valid", host_if.out_valid, 1);
    chk("t3_out_data", host_if.out_data, 8'h55);
    chk("t3_rx_read", uart_rx_read, 1);
    host_if.out_ready = 1'b1; step();
    host_if.out_ready = 1'b0;
    chk("t3_rx_read_end", uart_rx_read, 0);
    chk("t3_out_valid_end", host_if.out_valid, 0);

    // rx overrun: 17th byte dropped, then a byte accepted alongside a pop.
    uart_rx_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      uart_rx_data = 8'h80 + 8'(i);
      step();
    end
    uart_rx_data = 8'hEE; step();
    uart_rx_full = 1'b0;
    chk("t4_overrun", rx_overrun, 1);
    chk("t4_rx_level", rx_level, 16);
    chk("t4_head", host_if.out_data, 8'h80);
    clear_status = 1'b1; step();
    clear_status = 1'b0;
    chk("t4_cleared", rx_overrun, 0);
    uart_rx_full = 1'b1; uart_rx_data = 8'hEF; host_if.out_ready = 1'b1; step();
    uart_rx_full = 1'b0; host_if.out_ready = 1'b0;
    chk("t4_level_kept", rx_level, 16);
    chk("t4_head_next", host_if.out_data, 8'h81);
    chk("t4_no_overrun", rx_overrun, 0);
    host_if.out_ready = 1'b1;
    repeat (16) step();
    host_if.out_ready = 1'b0;
    chk("t4_drained", rx_level, 0);

    // Framing errors: three rising edges, then clear coincident with a fourth.
    for (int i = 0; i < 3; i++) begin
      uart_rx_error = 1'b1; step();
      uart_rx_error = 1'b0; step();
    end
    chk("t5_count3", rx_error_count, 3);
    uart_rx_error = 1'b1; clear_status = 1'b1; step();
    clear_status = 1'b0;
    chk("t5_clear_wins", rx_error_count, 1);
    uart_rx_error = 1'b0; step();

    // Reset with tx parked in HOLD and five rx bytes buffered.
    uart_rx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      uart_rx_data = 8'h61 + 8'(i);
      step();
    end
    uart_rx_full = 1'b0;
    host_if.in_valid = 1'b1; host_if.in_data = 8'h77; step();
    host_if.in_data = 8'h78; step();
    host_if.in_valid = 1'b0; uart_tx_full = 1'b1;
    repeat (2) step();
    chk("t6_pre_rx_level", rx_level, 5);
    chk("t6_pre_tx_level", tx_level, 1);
    reset = 1'b1; step();
    chk("t6_in_ready", host_if.in_ready, 1);
    chk("t6_out_valid", host_if.out_valid, 0);
    chk("t6_tx_level", tx_level, 0);
    chk("t6_rx_level", rx_level, 0);
    chk("t6_overrun", rx_overrun, 0);
    chk("t6_err_count", rx_error_count, 0);
    chk("t6_tx_write", uart_tx_write, 0);
    chk("t6_tx_data", uart_tx_data, 0);
    chk("t6_rx_read", uart_rx_read, 0);
    reset = 1'b0; uart_tx_full = 1'b0;
    repeat (6) step();
    chk("t6_total_writes", wlog.size(), 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_8n1_fifo_bridge.md
Name: uart_8n1_fifo_bridge

Overview:
Host-side buffering stage placed directly in front of uart_8n1.
- Downstream, it drains a transmit FIFO into the UART's single-byte tx holding register.
- Upstream, it captures each received byte into a receive FIFO, acknowledging the UART's receiver.
- It presents ready/valid byte streams to the host, plus FIFO levels, a sticky overrun flag and a framing-error counter.

Parameters:
FIFO_ADDR_W, 4, log2 of each FIFO depth (depth = 2**FIFO_ADDR_W, so 16 by default).

Ports:
clk  in  1  system clock; same clock as uart_8n1.
reset  in  1  synchronous, active-high.
in_data  in  8  host byte to transmit.
in_valid  in  1  host offers in_data.
in_ready  out  1  tx FIFO not full.
out_data  out  8  head of rx FIFO (show-ahead).
out_valid  out  1  rx FIFO not empty.
out_ready  in  1  host consumes out_data.
tx_level  out  FIFO_ADDR_W+1  tx FIFO occupancy.
rx_level  out  FIFO_ADDR_W+1  rx FIFO occupancy.
rx_overrun  out  1  sticky: a received byte was dropped.
rx_error_count  out  8  saturating count of receive framing errors.
clear_status  in  1  clears rx_overrun and rx_error_count.
uart_tx_data  out  8  byte presented to uart_8n1 tx_data.
uart_tx_write  out  1  one-cycle write strobe to uart_8n1 tx_write.
uart_tx_full  in  1  uart_8n1 tx_full.
uart_rx_data  in  8  uart_8n1 rx_data.
uart_rx_full  in  1  uart_8n1 rx_full; one-cycle pulse per received byte.
uart_rx_error  in  1  uart_8n1 rx_error level.
uart_rx_read  out  1  acknowledge pulse to uart_8n1 rx_read.

Behaviour:
- Reset values:
  - FIFOs empty: in_ready=1, out_valid=0, tx_level=0, rx_level=0.
  - rx_overrun=0, rx_error_count=0.
  - uart_tx_write=0, uart_tx_data=0, uart_rx_read=0.
  - tx FSM in IDLE.
- Host push: accepted on a cycle with in_valid && in_ready.
- Host pop: accepted on a cycle with out_valid && out_ready. out_data is always the head; no read latency.
- Levels: updated one cycle after push or pop. Simultaneous push and pop leaves the level unchanged.
- tx FSM, uart_tx_write and uart_tx_data registered:
  - IDLE -> WRITE when the tx FIFO is non-empty && !uart_tx_full. The head is popped into uart_tx_data and uart_tx_write=1 for exactly one cycle.
  - WRITE -> HOLD unconditionally. This covers the one-cycle delay before uart_tx_full rises and prevents a double write.
  - HOLD -> IDLE when !uart_tx_full.
  - Maximum issue rate: one byte per 3 cycles, then gated by the UART.
- tx FIFO full: in_ready=0 and the push is ignored. A push in the same cycle as an FSM pop while full is still refused; in_ready is derived from the registered level only.
- rx capture:
  - On each cycle with uart_rx_full=1, uart_rx_data is pushed into the rx FIFO.
  - uart_rx_read pulses for one cycle on the following cycle.
  - If the rx FIFO is full and there is no host pop that cycle, the byte is dropped, rx_overrun is set, and uart_rx_read still pulses.
  - If the rx FIFO is full and the host pops in the same cycle, the push is accepted.
- Framing errors:
  - A 0->1 edge on uart_rx_error increments rx_error_count, saturating at 255.
  - The previous value of uart_rx_error is registered; it resets to 0.
- clear_status: clears both rx_overrun and rx_error_count next cycle. If clear_status coincides with a new event, the event wins: flag=1 / count=1.
- Pointers: FIFO_ADDR_W bits, natural wrap; full/empty are derived from the level counter.
- Reset mid-transfer: FIFO contents are discarded. A byte already written to the UART is not recalled.

Decomposition:
- Shared package uart_8n1_pkg: byte width constant (8), tx FSM state encoding (IDLE, WRITE, HOLD), error counter width (8).
- One sub-module, uart_8n1_byte_fifo (params ADDR_W), instantiated twice.
  - Ports: push, push_data, pop, head, level, full, empty.
  - Same-cycle push+pop is allowed when full (net level unchanged); the parent decides policy.
  - Register-array storage.

Test Plan:
- Push 0xA5, 0x3C with uart_tx_full held 0 -> two uart_tx_write pulses at least 3 cycles apart, carrying 0xA5 then 0x3C; tx_level returns to 0.
- Hold uart_tx_full=1, push 16 bytes -> in_ready=0 and tx_level=16; a 17th push is ignored. Release uart_tx_full -> bytes are issued in order.
- Pulse uart_rx_full with 0x55 -> out_valid=1, out_data=0x55, uart_rx_read pulses one cycle later. Pop -> out_valid=0.
- Fill rx FIFO with 16 bytes, no pops, then pulse a 17th byte -> rx_overrun=1, rx_level stays 16, head unchanged. Repeat with out_ready=1 on the same cycle -> the byte is accepted and rx_overrun is unchanged.
- Toggle uart_rx_error 0->1 three times -> rx_error_count=3. Assert clear_status coincident with a 4th rising edge -> count=1.
- Assert reset while tx is in HOLD and the rx FIFO holds 5 bytes -> all outputs return to their reset values next cycle.
